// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase encoding,
// one approach's lamp triple and the round-robin grant helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_WALK    = 2'd3
  } phase_e;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_R = lamp_t'(3'b100);
  localparam lamp_t LAMP_Y = lamp_t'(3'b010);
  localparam lamp_t LAMP_G = lamp_t'(3'b001);

  // First set bit of pend searching last+1, last+2, ... modulo n.
  // Returns last when nothing is pending. n is 2..8.
  function automatic logic [2:0] rr_next(
    input logic [7:0] pend,
    input logic [2:0] last,
    input int         n
  );
    logic [2:0] pick;
    logic       found;
    logic [3:0] s;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      s = {1'b0, last} + k[3:0];
      if (s >= n[3:0]) s = s - n[3:0];
      if (!found && k <= n && pend[s[2:0]]) begin
        pick  = s[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer.
// Ports: clk, rst (sync, active-high), clear_i, enable_i, count_o.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic light controller: latched requests,
// round-robin service, rest-in-green, all-red clearance.
// Ports: clk, rst (sync, active-high), req[N_WAYS],
//   red/yellow/green[N_WAYS], active_way, phase;
//   ped_req/walk only when TRAFFIC_PED_EN is defined.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_WAYS     = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_WAYS-1:0]         req,
`ifdef TRAFFIC_PED_EN
  input  logic                      ped_req,
  output logic                      walk,
`endif
  output logic [N_WAYS-1:0]         red,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         green,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [1:0]                phase
);

  localparam int AW = $clog2(N_WAYS);

  // Timer reads DUR-1 on the last cycle of a DUR-cycle phase.
  localparam logic [CNT_W-1:0] LIM_G = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_Y = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_A = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_W = CNT_W'(WALK_CYC - 1);

  phase_e            state_q, state_d;
  logic [AW-1:0]     way_q, way_d, nxt;
  logic [N_WAYS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt, lim;
  logic              done, tmr_clr, ped_pend;

  phase_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clr),
    .enable_i (1'b1),
    .count_o  (cnt)
  );

  assign tmr_clr = (state_d != state_q);

  always_comb begin
    lim = LIM_A;
    unique case (state_q)
      PH_ALL_RED: lim = LIM_A;
      PH_GREEN:   lim = LIM_G;
      PH_YELLOW:  lim = LIM_Y;
      PH_WALK:    lim = LIM_W;
    endcase
  end

  assign done = (cnt >= lim);
  assign nxt  = AW'(rr_next(8'(pend_q), 3'(way_q), N_WAYS));

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    unique case (state_q)
      PH_ALL_RED: begin
        if (done && ped_pend) begin
          state_d = PH_WALK;
        end else if (done && (|pend_q)) begin
          state_d = PH_GREEN;
          way_d   = nxt;
        end
      end
      PH_GREEN: begin
        if (done && ((|pend_q) || ped_pend)) state_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (done) state_d = PH_ALL_RED;
      end
      PH_WALK: begin
        if (done) state_d = PH_ALL_RED;
      end
    endcase
  end

  // Not latched during own green; cleared on the grant edge,
  // which wins over a same-cycle request.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_WAYS; i++) begin
      if (req[i] && !(state_q == PH_GREEN && way_q == AW'(i)))
        pend_d[i] = 1'b1;
      if (state_d == PH_GREEN && state_q != PH_GREEN
          && way_d == AW'(i))
        pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_ALL_RED;
      way_q   <= AW'(N_WAYS - 1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      pend_q  <= pend_d;
    end
  end

`ifdef TRAFFIC_PED_EN
  logic ped_q, ped_d;

  always_comb begin
    ped_d = ped_q;
    if (ped_req && state_q != PH_WALK) ped_d = 1'b1;
    if (state_d == PH_WALK && state_q != PH_WALK) ped_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ped_q <= 1'b0;
    else     ped_q <= ped_d;
  end

  assign ped_pend = ped_q;
  assign walk     = (state_q == PH_WALK);
`else
  assign ped_pend = 1'b0;
`endif

  always_comb begin
    lamp_t lamp;
    red    = '0;
    yellow = '0;
    green  = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      lamp = LAMP_R;
      if (way_q == AW'(i)) begin
        if (state_q == PH_GREEN)       lamp = LAMP_G;
        else if (state_q == PH_YELLOW) lamp = LAMP_Y;
      end
      red[i]    = lamp.r;
      yellow[i] = lamp.y;
      green[i]  = lamp.g;
    end
  end

  assign active_way = way_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (N_WAYS=3, G=6, Y=3, AR=2).
// Vector table plus hand-written multi-cycle sequences.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] red, yellow, green;
  logic [1:0] active_way, phase;
`ifdef TRAFFIC_PED_EN
  logic       ped_req;
  logic       walk;
`endif

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_WAYS     (3),
    .CNT_W      (8),
    .GREEN_CYC  (6),
    .YELLOW_CYC (3),
    .ALLRED_CYC (2),
    .WALK_CYC   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef TRAFFIC_PED_EN
    .ped_req    (ped_req),
    .walk       (walk),
`endif
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_way (active_way),
    .phase      (phase)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rs;
    logic [2:0] rq;
    logic [1:0] ph;
    logic [1:0] way;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r,
                     input logic [2:0] rq,
                     input logic [1:0] ph,
                     input logic [1:0] w);
    vec_t v;
    v.rs  = r;
    v.rq  = rq;
    v.ph  = ph;
    v.way = w;
    repeat (n) tbl.push_back(v);
  endtask

  function automatic logic [8:0] lamps(input logic [1:0] ph,
                                       input logic [1:0] w);
    logic [2:0] r, y, g;
    r = 3'b111;
    y = 3'b000;
    g = 3'b000;
    if (ph == 2'd1) begin
      r[w] = 1'b0;
      g[w] = 1'b1;
    end else if (ph == 2'd2) begin
      r[w] = 1'b0;
      y[w] = 1'b1;
    end
    return {r, y, g};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] rq);
    logic ok;
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
    ok = ((red | yellow | green) == 3'b111)
      && ((red & yellow) == 3'b000)
      && ((red & green) == 3'b000)
      && ((yellow & green) == 3'b000)
      && ($countones(~red) <= 1);
    chk("invariant", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b0;
`endif

    add(1,  1'b1, 3'b000, 2'd0, 2'd2);
    add(20, 1'b0, 3'b000, 2'd0, 2'd2);
    add(1,  1'b0, 3'b010, 2'd0, 2'd2);
    add(1,  1'b0, 3'b000, 2'd1, 2'd1);
    add(1,  1'b0, 3'b000, 2'd1, 2'd1);
    add(1,  1'b0, 3'b101, 2'd1, 2'd1);
    add(3,  1'b0, 3'b000, 2'd1, 2'd1);
    add(1,  1'b0, 3'b000, 2'd2, 2'd1);
    add(2,  1'b0, 3'b000, 2'd2, 2'd1);
    add(2,  1'b0, 3'b000, 2'd0, 2'd1);
    add(1,  1'b0, 3'b000, 2'd1, 2'd2);
    add(5,  1'b0, 3'b000, 2'd1, 2'd2);
    add(1,  1'b0, 3'b000, 2'd2, 2'd2);
    add(2,  1'b0, 3'b000, 2'd2, 2'd2);
    add(2,  1'b0, 3'b000, 2'd0, 2'd2);
    add(1,  1'b0, 3'b000, 2'd1, 2'd0);
    add(15, 1'b0, 3'b000, 2'd1, 2'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].rs, tbl[k].rq);
      chk($sformatf("vec%0d", k),
          32'({red, yellow, green, phase, active_way}),
          32'({lamps(tbl[k].ph, tbl[k].way),
               tbl[k].ph, tbl[k].way}));
    end

    // Reset in the middle of yellow.
    cyc(1'b0, 3'b010);
    chk("pre_yel_green", 32'(green), 32'(3'b001));
    cyc(1'b0, 3'b000);
    chk("yel_entered", 32'(phase), 32'd2);
    cyc(1'b1, 3'b000);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_red", 32'(red), 32'(3'b111));
    chk("rst_way", 32'(active_way), 32'd2);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 3'b000);
      chk("rst_no_green", 32'({phase, green}), 32'd0);
    end

    // Request held through its own green is not re-latched.
    cyc(1'b1, 3'b000);
    cyc(1'b0, 3'b010);
    cyc(1'b0, 3'b010);
    chk("hold_grant1", 32'(green), 32'(3'b010));
    cyc(1'b0, 3'b010);
    cyc(1'b0, 3'b010);
    cyc(1'b0, 3'b011);
    cyc(1'b0, 3'b010);
    cyc(1'b0, 3'b010);
    chk("hold_still_green", 32'(phase), 32'd1);
    cyc(1'b0, 3'b010);
    chk("hold_yellow", 32'(yellow), 32'(3'b010));
    repeat (3) cyc(1'b0, 3'b000);
    chk("hold_allred", 32'(phase), 32'd0);
    cyc(1'b0, 3'b000);
    cyc(1'b0, 3'b000);
    chk("hold_grant0", 32'({green, active_way}),
        32'({3'b001, 2'd0}));
    for (int k = 0; k < 15; k++) begin
      cyc(1'b0, 3'b000);
      chk("hold_rest0", 32'(green), 32'(3'b001));
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian call during green[0] with way 1 waiting.
    cyc(1'b1, 3'b000);
    cyc(1'b0, 3'b001);
    cyc(1'b0, 3'b000);
    chk("ped_green0", 32'(green), 32'(3'b001));
    ped_req = 1'b1;
    cyc(1'b0, 3'b010);
    ped_req = 1'b0;
    repeat (5) cyc(1'b0, 3'b000);
    chk("ped_yellow", 32'(phase), 32'd2);
    repeat (3) cyc(1'b0, 3'b000);
    chk("ped_allred1", 32'(phase), 32'd0);
    repeat (2) cyc(1'b0, 3'b000);
    chk("ped_walk", 32'({phase, walk, red}),
        32'({2'd3, 1'b1, 3'b111}));
    repeat (3) cyc(1'b0, 3'b000);
    chk("ped_walk_end", 32'(walk), 32'd1);
    cyc(1'b0, 3'b000);
    chk("ped_allred2", 32'({phase, walk}), 32'd0);
    repeat (2) cyc(1'b0, 3'b000);
    chk("ped_green1", 32'(green), 32'(3'b010));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
